// File: rtl/mips_tb_pkg.sv
// Shared types, constants and helpers for the MIPS testbench instruction harness.
package mips_tb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      HALTED    = 2'd2,
      TIMED_OUT = 2'd3
   } tb_state_t;

   localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
   localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
   localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;

   function automatic logic [31:0] bswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/mips_tb_run_monitor.sv
// Run monitor: tracks CPU run state, counts enabled cycles, detects halt or timeout.
module mips_tb_run_monitor
   import mips_tb_pkg::*;
#(
   parameter int unsigned MAX_CYCLES = 1000,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             active,
   input  logic [31:0]      instr_address,
   input  logic [31:0]      register_v0,
   input  logic             run_en,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_count,
   output logic [31:0]      result_v0
);

   localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(MAX_CYCLES - 1);
   localparam logic [CNT_W-1:0] BUDGET_CNT = CNT_W'(MAX_CYCLES);

   tb_state_t        state, state_next;
   logic             done_next, timeout_next;
   logic [CNT_W-1:0] count_next;
   logic [31:0]      v0_next;
   logic             halt_seen, budget_edge;

   // The CPU signals halt by dropping active while fetching address 0.
   assign halt_seen   = !active && (instr_address == HALT_ADDR);
   assign budget_edge = run_en && (cycle_count == LAST_CNT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         done        <= 1'b0;
         timeout     <= 1'b0;
         cycle_count <= '0;
         result_v0   <= 32'h0;
      end else begin
         state       <= state_next;
         done        <= done_next;
         timeout     <= timeout_next;
         cycle_count <= count_next;
         result_v0   <= v0_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (active) state_next = RUN;
         RUN: begin
            if (halt_seen)        state_next = HALTED;
            else if (budget_edge) state_next = TIMED_OUT;
         end
         default: state_next = state;
      endcase
   end

   // Halt takes priority over the final budget edge.
   always_comb begin
      done_next    = done;
      timeout_next = timeout;
      count_next   = cycle_count;
      v0_next      = result_v0;
      if (state == RUN) begin
         if (halt_seen) begin
            done_next = 1'b1;
            v0_next   = register_v0;
         end else if (budget_edge) begin
            timeout_next = 1'b1;
            count_next   = BUDGET_CNT;
         end else if (run_en) begin
            count_next = cycle_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/mips_tb_instr_mem.sv
// Loadable instruction memory with zero-latency fetch, optional byte swap and run monitor.
module mips_tb_instr_mem
   import mips_tb_pkg::*;
#(
   parameter int unsigned  DEPTH      = 64,
   parameter logic [31:0]  BASE_ADDR  = RESET_VECTOR,
   parameter bit           BYTE_SWAP  = 1'b1,
   parameter int unsigned  MAX_CYCLES = 1000,
   parameter int unsigned  CNT_W      = 32,
   localparam int unsigned IDX_W      = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_en,
   input  logic [IDX_W-1:0] load_index,
   input  logic [31:0]      load_data,
   input  logic [31:0]      instr_address,
   output logic [31:0]      instr_readdata,
   output logic             addr_fault,
   input  logic             active,
   input  logic [31:0]      register_v0,
   input  logic             run_en,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_count,
   output logic [31:0]      result_v0
);

   localparam logic [31:0] WINDOW = 32'(DEPTH * 4);

   logic [31:0]      mem [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [31:0]      off;
   logic [31:0]      word;
   logic             hit;
   logic [IDX_W-1:0] idx;

   // Program words are not reset; the valid bits gate them to NOP instead.
   always_ff @(posedge clk) begin
      if (load_en) mem[load_index] <= load_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       valid             <= '0;
      else if (load_en) valid[load_index] <= 1'b1;
   end

   always_comb begin
      off  = instr_address - BASE_ADDR;
      hit  = (off < WINDOW) && (off[1:0] == 2'b00);
      idx  = off[IDX_W+1:2];
      word = NOP_WORD;
      if (hit && valid[idx]) word = mem[idx];
   end

   assign instr_readdata = BYTE_SWAP ? bswap32(word) : word;
   assign addr_fault     = active & ~hit;

   mips_tb_run_monitor #(
      .MAX_CYCLES (MAX_CYCLES),
      .CNT_W      (CNT_W)
   ) u_run_monitor (
      .clk           (clk),
      .reset         (reset),
      .active        (active),
      .instr_address (instr_address),
      .register_v0   (register_v0),
      .run_en        (run_en),
      .done          (done),
      .timeout       (timeout),
      .cycle_count   (cycle_count),
      .result_v0     (result_v0)
   );

endmodule

// File: tb/tb_mips_tb_instr_mem.sv
// Directed bench: swapping instance with a 20-cycle budget, plus a pass-through instance.
module tb_mips_tb_instr_mem;

   localparam logic [31:0] BASE = 32'hBFC0_0000;

   logic        clk;
   logic        reset;
   logic        load_en;
   logic [5:0]  load_index;
   logic [31:0] load_data;
   logic [31:0] instr_address;
   logic        active;
   logic [31:0] register_v0;
   logic        run_en;

   logic [31:0] rd, ns_rd;
   logic        fault, ns_fault;
   logic        done, ns_done;
   logic        timeout, ns_timeout;
   logic [31:0] cycle_count, ns_cycle_count;
   logic [31:0] result_v0, ns_result_v0;

   int checks = 0;
   int errors = 0;

   mips_tb_instr_mem #(.DEPTH(64), .BYTE_SWAP(1'b1), .MAX_CYCLES(20), .CNT_W(32)) u_dut (
      .clk (clk), .reset (reset), .load_en (load_en), .load_index (load_index),
      .load_data (load_data), .instr_address (instr_address), .instr_readdata (rd),
      .addr_fault (fault), .active (active), .register_v0 (register_v0), .run_en (run_en),
      .done (done), .timeout (timeout), .cycle_count (cycle_count), .result_v0 (result_v0)
   );

   mips_tb_instr_mem #(.DEPTH(64), .BYTE_SWAP(1'b0), .MAX_CYCLES(1000), .CNT_W(32)) u_dut_ns (
      .clk (clk), .reset (reset), .load_en (load_en), .load_index (load_index),
      .load_data (load_data), .instr_address (instr_address), .instr_readdata (ns_rd),
      .addr_fault (ns_fault), .active (active), .register_v0 (register_v0), .run_en (run_en),
      .done (ns_done), .timeout (ns_timeout), .cycle_count (ns_cycle_count),
      .result_v0 (ns_result_v0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [5:0] idx, input logic [31:0] data);
      load_en    = 1'b1;
      load_index = idx;
      load_data  = data;
      tick();
      load_en    = 1'b0;
   endtask

   // Called one time unit after an edge: a 3 ns pulse well clear of the next edge.
   task automatic pulse_reset();
      reset = 1'b0;
      #3;
      reset = 1'b1;
   endtask

   task automatic run_scenario(input string tag);
      load(6'd0, 32'h2484_6006);
      load(6'd1, 32'h0004_1480);
      load(6'd2, 32'h0000_0008);
      load(6'd3, 32'h2400_0000);
      active        = 1'b1;
      run_en        = 1'b1;
      register_v0   = 32'h0;
      instr_address = BASE;
      #1;
      check({tag, "_fetch0"}, rd, 32'h0660_8424);
      check({tag, "_fetch0_ns"}, ns_rd, 32'h2484_6006);
      tick();
      check({tag, "_count_start"}, cycle_count, 32'd0);
      for (int i = 1; i <= 5; i++) begin
         instr_address = BASE + 32'(4 * (i % 4));
         tick();
      end
      check({tag, "_count_run"}, cycle_count, 32'd5);
      active        = 1'b0;
      instr_address = 32'h0;
      register_v0   = 32'h8018_0000;
      #1;
      check({tag, "_halt_nofault"}, {31'd0, fault}, 32'd0);
      check({tag, "_done_pre"}, {31'd0, done}, 32'd0);
      tick();
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
      check({tag, "_v0"}, result_v0, 32'h8018_0000);
      check({tag, "_count_halt"}, cycle_count, 32'd5);
      register_v0   = 32'hDEAD_BEEF;
      active        = 1'b1;
      instr_address = BASE;
      tick();
      tick();
      check({tag, "_v0_hold"}, result_v0, 32'h8018_0000);
      check({tag, "_count_hold"}, cycle_count, 32'd5);
      active = 1'b0;
   endtask

   initial begin
      reset         = 1'b0;
      load_en       = 1'b0;
      load_index    = 6'd0;
      load_data     = 32'h0;
      instr_address = BASE;
      active        = 1'b0;
      register_v0   = 32'h0;
      run_en        = 1'b0;
      #12;
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_timeout", {31'd0, timeout}, 32'd0);
      check("rst_count", cycle_count, 32'd0);
      check("rst_v0", result_v0, 32'h0);
      reset = 1'b1;
      tick();

      // Empty memory: NOP everywhere, fault only outside/misaligned while active.
      instr_address = 32'hBFC0_0010;
      #1;
      check("empty_nop", rd, 32'h0);
      check("empty_nofault", {31'd0, fault}, 32'd0);
      instr_address = 32'hBFC0_0102;
      active        = 1'b1;
      #1;
      check("outside_fault", {31'd0, fault}, 32'd1);
      check("outside_fault_ns", {31'd0, ns_fault}, 32'd1);
      check("outside_data", rd, 32'h0);
      instr_address = 32'hBFC0_0006;
      #1;
      check("misaligned_fault", {31'd0, fault}, 32'd1);
      instr_address = 32'hBFC0_00FC;
      #1;
      check("last_word_nofault", {31'd0, fault}, 32'd0);
      instr_address = 32'hBFC0_0102;
      active        = 1'b0;
      #1;
      check("inactive_nofault", {31'd0, fault}, 32'd0);
      tick();

      // Load visibility around the write edge, both swap settings.
      instr_address = BASE;
      load_en       = 1'b1;
      load_index    = 6'd0;
      load_data     = 32'h1122_3344;
      #1;
      check("load_before_edge", ns_rd, 32'h0);
      tick();
      load_en = 1'b0;
      check("load_passthru", ns_rd, 32'h1122_3344);
      check("load_swapped", rd, 32'h4433_2211);
      load_en   = 1'b1;
      load_data = 32'hAABB_CCDD;
      #1;
      check("overwrite_old", ns_rd, 32'h1122_3344);
      tick();
      load_en = 1'b0;
      check("overwrite_new", ns_rd, 32'hAABB_CCDD);

      run_scenario("prog");
      check("prog_ns_done", {31'd0, ns_done}, 32'd1);
      check("prog_ns_count", ns_cycle_count, 32'd5);
      check("prog_ns_v0", ns_result_v0, 32'h8018_0000);

      // Reset in the middle of a run clears monitor and valid bits at once.
      pulse_reset();
      tick();
      load(6'd0, 32'h2484_6006);
      active        = 1'b1;
      run_en        = 1'b1;
      instr_address = BASE;
      tick();
      tick();
      tick();
      tick();
      check("midrun_count", cycle_count, 32'd3);
      reset = 1'b0;
      #1;
      check("midrst_count", cycle_count, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_timeout", {31'd0, timeout}, 32'd0);
      check("midrst_v0", result_v0, 32'h0);
      check("midrst_valid", rd, 32'h0);
      active = 1'b0;
      #2;
      reset = 1'b1;
      tick();
      check("post_rst_idle", cycle_count, 32'd0);
      run_scenario("rerun");

      // Branch-to-self loop runs out the 20-cycle budget; run_en=0 holds the counter.
      pulse_reset();
      tick();
      load(6'd0, 32'h1000_FFFF);
      load(6'd1, 32'h0000_0000);
      active        = 1'b1;
      run_en        = 1'b1;
      instr_address = BASE;
      tick();
      for (int i = 0; i < 19; i++) begin
         instr_address = (i % 2 == 0) ? BASE + 32'd4 : BASE;
         tick();
      end
      check("to_count19", cycle_count, 32'd19);
      check("to_not_yet", {31'd0, timeout}, 32'd0);
      run_en = 1'b0;
      tick();
      check("to_hold", cycle_count, 32'd19);
      check("to_hold_flag", {31'd0, timeout}, 32'd0);
      run_en = 1'b1;
      tick();
      check("to_flag", {31'd0, timeout}, 32'd1);
      check("to_count", cycle_count, 32'd20);
      check("to_done0", {31'd0, done}, 32'd0);
      check("to_ns_notimeout", {31'd0, ns_timeout}, 32'd0);
      check("to_ns_count", ns_cycle_count, 32'd20);
      tick();
      active        = 1'b0;
      instr_address = 32'h0;
      tick();
      check("to_terminal_done", {31'd0, done}, 32'd0);
      check("to_terminal_count", cycle_count, 32'd20);
      check("to_terminal_flag", {31'd0, timeout}, 32'd1);

      // Halt on the same edge as the final budget edge: halt wins.
      pulse_reset();
      tick();
      active        = 1'b1;
      run_en        = 1'b1;
      instr_address = BASE;
      tick();
      for (int i = 0; i < 19; i++) tick();
      check("tie_count19", cycle_count, 32'd19);
      active        = 1'b0;
      instr_address = 32'h0;
      register_v0   = 32'h1234_5678;
      tick();
      check("tie_done", {31'd0, done}, 32'd1);
      check("tie_timeout", {31'd0, timeout}, 32'd0);
      check("tie_count", cycle_count, 32'd19);
      check("tie_v0", result_v0, 32'h1234_5678);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_tb_instr_mem.md
Name: mips_tb_instr_mem

Overview:
- Reusable, parametrised instruction-side harness for mips_cpu_harvard testbenches.
- Replaces per-test hard-coded instruction decode with a loadable word array.
- Presents an optional byte swap to the CPU's instr_readdata port.
- Contains a run monitor that detects the halt condition, counts cycles, flags timeouts and captures register_v0 at halt.

Parameters:
- DEPTH, 64: program words held; power of two; IDX_W = $clog2(DEPTH).
- BASE_ADDR, 32'hBFC00000: byte address of word 0 (the reset vector).
- BYTE_SWAP, 1: 1 = output bytes reversed ({b[7:0],b[15:8],b[23:16],b[31:24]}); 0 = pass-through.
- MAX_CYCLES, 1000: RUN-state cycle budget before timeout.
- CNT_W, 32: cycle_count width; must hold MAX_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_en  in  1  write load_data to word load_index this edge.
- load_index  in  IDX_W  word index for load.
- load_data  in  32  program word, stored in logical (non-swapped) order.
- instr_address  in  32  CPU fetch byte address.
- instr_readdata  out  32  fetched word after optional byte swap.
- addr_fault  out  1  fetch outside window or misaligned while active.
- active  in  1  CPU active flag.
- register_v0  in  32  CPU $v0 debug output.
- run_en  in  1  cycle-count enable (tie to clk_enable).
- done  out  1  sticky: halt detected.
- timeout  out  1  sticky: MAX_CYCLES reached without halt.
- cycle_count  out  CNT_W  RUN cycles elapsed.
- result_v0  out  32  register_v0 captured at halt.

Behaviour:
Reset (reset=0, asynchronous):
- valid[DEPTH-1:0]=0, state=IDLE, done=0, timeout=0, cycle_count=0, result_v0=0.
- Word array is not reset; invalid words read as NOP.

Fetch path (combinational, zero latency; the CPU requires same-cycle data):
- off = instr_address - BASE_ADDR (32-bit wrap).
- hit = off < DEPTH*4 and off[1:0]==0; idx = off[IDX_W+1:2].
- Hit with valid[idx] set: word = mem[idx]. Otherwise word = 32'h0 (NOP).
- instr_readdata = BYTE_SWAP ? swap(word) : word.
- addr_fault = active & ~hit. Never asserted while active=0, so the halt fetch at address 0 does not fault.

Load:
- When load_en=1, on the rising edge: mem[load_index] <= load_data and valid[load_index] <= 1.
- Loads are legal in any state.
- A fetch of the same index returns the old word until the edge and the new word after it.

Run monitor FSM (states IDLE, RUN, HALTED, TIMED_OUT):
- IDLE -> RUN: on the edge where active=1. The counter does not increment on that edge.
- In RUN, each edge with run_en=1: cycle_count increments.
- RUN -> HALTED: on the edge where active=0 and instr_address==0. done<=1, result_v0<=register_v0. The counter does not increment on that edge.
- RUN -> TIMED_OUT: on the edge where run_en=1, no halt, and cycle_count==MAX_CYCLES-1. cycle_count<=MAX_CYCLES, timeout<=1.
- Halt and timeout on the same edge: halt wins; done=1, timeout=0.
- run_en=0 in RUN: counter holds; halt detection is still active.
- HALTED and TIMED_OUT are terminal until reset. cycle_count, result_v0 and the flags hold.
- Reset asserted mid-run: immediate return to IDLE with all monitor outputs cleared.

Decomposition:
- Package mips_tb_pkg holds:
  - tb_state_t enum (IDLE, RUN, HALTED, TIMED_OUT).
  - NOP_WORD = 32'h0.
  - RESET_VECTOR = 32'hBFC00000.
  - HALT_ADDR = 32'h0.
  - byte-swap function bswap32.
- Sub-module mips_tb_run_monitor holds the FSM, counter and capture logic. The top level holds the array, valid bits and fetch/load logic.

Test Plan:
- Load words 0..3 = 24846006, 00041480, 00000008, 24000000 with BYTE_SWAP=1, then run the CPU. Required: done=1, timeout=0, result_v0=32'h80180000, cycle_count between 4 and 10.
- BYTE_SWAP=0, word 0 loaded 32'h11223344, instr_address=BFC00000 -> instr_readdata=11223344. With BYTE_SWAP=1 -> 44332211.
- No words loaded, fetch BFC00010 -> 0; fetch BFC00102 (misaligned/outside) with active=1 -> addr_fault=1, readdata 0; same address with active=0 -> addr_fault=0.
- MAX_CYCLES=20, program is a branch-to-self loop -> timeout=1 after exactly 20 run_en cycles, cycle_count=20, done stays 0.
- Force halt and the final budget edge on the same edge (MAX_CYCLES tuned) -> done=1, timeout=0.
- Assert reset for 3 ns mid-RUN, between edges -> all monitor outputs 0 immediately and valid cleared. After release, reload the program and rerun -> same result as the first scenario.
